bus_ram_target: RTL and testbench
=================================

BUS_RAM_TARGET -- requirements
Module: bus_ram_target

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, meaning word-address width; RAM depth is 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, meaning byte base address of the RAM window; must be aligned to 4*2^ADDR_BITS.
REQ-003 SHALL have parameter WAIT_STATES, default 1, meaning extra cycles inserted before each access; legal range 0..15.
REQ-004 SHALL have port i_clock, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit, meaning reset; asynchronous, active-low.
REQ-006 SHALL have port i_request, input, 1 bit, meaning the initiator requests a transfer; held high until o_ready is seen.
REQ-007 SHALL have port i_rw, input, 1 bit, meaning transfer direction: 1 = write, 0 = read.
REQ-008 SHALL have port i_address, input, 32 bits, meaning byte address; bits [1:0] ignored.
REQ-009 SHALL have port i_wdata, input, 32 bits, meaning write data.
REQ-010 SHALL have port o_ready, output, 1 bit, meaning the transfer is complete.
REQ-011 SHALL have port o_rdata, output, 32 bits, meaning read data; valid while o_ready=1 for a read.
REQ-012 SHALL have port o_error, output, 1 bit, meaning the address is outside the window; valid while o_ready=1.

Function
REQ-013 SHALL implement a 4-phase handshake: request rises; ready rises; request falls; ready falls; no new transfer until both are low.
REQ-014 SHALL use FSM states IDLE, WAIT, ACCESS, DONE.
REQ-015 IDLE: on an edge with i_request=1, latch i_rw, i_address, i_wdata and set wait counter=WAIT_STATES; go to WAIT if WAIT_STATES>0, else ACCESS.
REQ-016 WAIT: decrement counter each edge; go to ACCESS on the edge where counter==1.
REQ-017 ACCESS: in-window write stores latched wdata at word index addr[ADDR_BITS+1:2]; in-window read registers RAM word into o_rdata; set o_ready=1, go to DONE.
REQ-018 Out-of-window access (addr < BASE or addr >= BASE+4*2^ADDR_BITS) SHALL NOT touch RAM; in ACCESS it drives o_rdata=0 and o_error=1 with o_ready=1.
REQ-019 DONE: hold o_ready, o_rdata and o_error stable while i_request=1; on an edge with i_request=0, clear o_ready and o_error and go to IDLE.
REQ-020 Latency: o_ready SHALL be high after the (WAIT_STATES+2)th rising edge, counting the first edge that samples i_request=1 in IDLE.
REQ-021 Abort: i_request=0 sampled in WAIT or ACCESS SHALL return to IDLE with no RAM write and o_ready staying 0.
REQ-022 Changes on i_rw, i_address and i_wdata after the IDLE latch edge SHALL be ignored for that transfer.
REQ-023 Back-to-back: a request high in the cycle after DONE->IDLE SHALL start a new transfer on that edge.
REQ-024 o_rdata after a write SHALL hold its previous value; o_error SHALL be 0 for in-window accesses.

Reset
REQ-025 Assertion of i_reset (low), at any time including mid-transfer, SHALL force state=IDLE, o_ready=0, o_error=0, o_rdata=0, counter=0 immediately, without waiting for a clock edge.
REQ-026 Reset SHALL NOT clear RAM contents; contents after power-up are undefined.
REQ-027 An interrupted write SHALL NOT be committed unless its ACCESS edge occurred before reset asserted.
REQ-028 After i_reset rises, the first edge SHALL be able to accept a request.

Verification
REQ-029 WAIT_STATES=1, write 0xDEADBEEF to 0x0000_0010 -> o_ready high after 3rd edge; read 0x0000_0010 -> o_rdata=0xDEADBEEF, o_error=0.
REQ-030 WAIT_STATES=0, read of 0x0000_0013 after a write to 0x0000_0010 -> same word returned (low bits ignored); o_ready after 2nd edge.
REQ-031 ADDR_BITS=10, BASE=0, write to 0x0000_1000 -> o_ready=1, o_error=1, o_rdata=0; word 0 unchanged.
REQ-032 Hold i_request high 5 cycles after o_ready -> o_ready, o_rdata stay stable; drop request -> o_ready=0 one edge later, back in IDLE.
REQ-033 Drop i_request during WAIT (WAIT_STATES=3) on a write of 0x12345678 to 0x20 -> no ready; subsequent read of 0x20 returns old value.
REQ-034 Assert i_reset low in DONE -> o_ready=0 and o_rdata=0 before the next edge; after release, a new read completes normally.

Source files
------------

// File: rtl/bus_ram_target.sv
// Word-addressed RAM slave behind a 4-phase request/ready handshake.
// Accesses are delayed by WAIT_STATES cycles; addresses outside the window report an error.
module bus_ram_target #(
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_error
);

  localparam int          DEPTH = 1 << ADDR_BITS;
  localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd4 << ADDR_BITS);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  rw_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mem [DEPTH];
  logic                  latch_en, access_en, release_en;
  logic                  in_window, ram_we;
  logic [ADDR_BITS-1:0]  word_idx;

  // 33-bit compare keeps the upper bound exact even when the window ends at 4 GiB
  assign in_window = ({1'b0, addr_q} >= {1'b0, BASE}) && ({1'b0, addr_q} < LIMIT);
  assign word_idx  = addr_q[ADDR_BITS+1:2];
  assign ram_we    = access_en && rw_q && in_window;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (latch_en)
        cnt <= WS;
      else if (state == WAIT)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_request) state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (!i_request) state_nxt = IDLE;
               else if (cnt == 4'd1) state_nxt = ACCESS;
      ACCESS:  state_nxt = i_request ? DONE : IDLE;
      DONE:    if (!i_request) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    latch_en   = 1'b0;
    access_en  = 1'b0;
    release_en = 1'b0;
    case (state)
      IDLE:    latch_en   = i_request;
      ACCESS:  access_en  = i_request;
      DONE:    release_en = !i_request;
      default: ;
    endcase
  end

  // Transfer attributes are captured once; later input changes are ignored
  always_ff @(posedge i_clock) begin
    if (latch_en) begin
      rw_q    <= i_rw;
      addr_q  <= i_address;
      wdata_q <= i_wdata;
    end
  end

  always_ff @(posedge i_clock) begin
    if (ram_we)
      mem[word_idx] <= wdata_q;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_ready <= 1'b0;
      o_error <= 1'b0;
      o_rdata <= 32'd0;
    end else if (access_en) begin
      o_ready <= 1'b1;
      o_error <= !in_window;
      if (!in_window)
        o_rdata <= 32'd0;
      else if (!rw_q)
        o_rdata <= mem[word_idx];
    end else if (release_en) begin
      o_ready <= 1'b0;
      o_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_ram_target.sv
// Scoreboard bench for bus_ram_target: driver pushes expected responses,
// a negedge monitor pops them when o_ready rises and checks them while it is held.
module tb_bus_ram_target;

  localparam int          AB        = 10;
  localparam int          WS        = 1;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam longint      WIN_BYTES = longint'(4) << AB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  always #5 clk = ~clk;

  bus_ram_target #(.ADDR_BITS(AB), .BASE(BASE), .WAIT_STATES(WS)) dut (
    .i_clock  (clk),
    .i_reset  (rst_n),
    .i_request(req),
    .i_rw     (rw),
    .i_address(addr),
    .i_wdata  (wdata),
    .o_ready  (ready),
    .o_rdata  (rdata),
    .o_error  (err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          edge_no;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model_mem [int];
  logic [31:0] model_rdata = 32'd0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + WIN_BYTES;
  endfunction

  function automatic int word_key(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Monitor: first cycle of o_ready pops an expectation, later cycles check stability
  exp_t cur;
  bit   active = 1'b0;
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (!active) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got ready=1 with nothing outstanding, expected 0 (t=%0t)", $time);
        end else begin
          cur = sbq.pop_front();
          check("latency_edge", cyc, cur.edge_no);
          check("rdata", rdata, cur.rdata);
          check("error", {31'b0, err}, {31'b0, cur.err});
        end
        active = 1'b1;
      end else begin
        check("hold_rdata", rdata, cur.rdata);
        check("hold_error", {31'b0, err}, {31'b0, cur.err});
      end
    end else begin
      active = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, ready}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_error"}, {31'b0, err}, 32'd0);
  endtask

  // Called at a negedge; returns at a negedge with request low and ready low
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int hold, input bit rst_in_done = 1'b0);
    exp_t e;
    int   n;
    req = 1'b1; rw = w; addr = a; wdata = d;
    if (in_win(a)) begin
      if (w) model_mem[word_key(a)] = d;
      else   model_rdata = model_mem[word_key(a)];
      e.err = 1'b0;
    end else begin
      model_rdata = 32'd0;
      e.err = 1'b1;
    end
    e.rdata   = model_rdata;
    e.edge_no = cyc + WS + 2;
    sbq.push_back(e);
    @(negedge clk);
    rw = 1'($urandom); addr = $urandom; wdata = $urandom;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected 1", n + 1);
    end
    if (rst_in_done) begin
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_in_done");
      model_rdata = 32'd0;
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      repeat (hold) @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      check("release_ready", {31'b0, ready}, 32'd0);
    end
  endtask

  // Starts a transfer and kills it after 'edges' clock edges by dropping request or by reset
  task automatic abort_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input int edges, input bit by_reset);
    req = 1'b1; rw = w; addr = a; wdata = d;
    repeat (edges) @(negedge clk);
    if (by_reset) begin
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset_mid_xfer");
      model_rdata = 32'd0;
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      req = 1'b0;
      @(negedge clk);
    end
    check("abort_no_ready", {31'b0, ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          w;
    int          key;
    logic [31:0] a;

    #3 check_reset_outputs("power_on_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    xfer(1'b0, 32'h0000_0010, 32'h0, 0);
    xfer(1'b0, 32'h0000_0013, 32'h0, 1);
    xfer(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 0);
    xfer(1'b1, 32'h0000_1000, 32'h5555_AAAA, 0);
    xfer(1'b0, 32'hFFFF_FFFC, 32'h0, 0);
    xfer(1'b0, 32'h0000_0000, 32'h0, 0);
    xfer(1'b0, 32'h0000_0010, 32'h0, 5);
    xfer(1'b1, 32'h0000_0FFC, 32'h7777_0001, 2);
    xfer(1'b0, 32'h0000_0FFE, 32'h0, 0);

    xfer(1'b1, 32'h0000_0020, 32'hAAAA_5555, 0);
    abort_xfer(1'b1, 32'h0000_0020, 32'h1234_5678, 1, 1'b0);
    xfer(1'b0, 32'h0000_0020, 32'h0, 0);
    abort_xfer(1'b1, 32'h0000_0020, 32'h1234_5678, 2, 1'b0);
    xfer(1'b0, 32'h0000_0020, 32'h0, 0);
    abort_xfer(1'b1, 32'h0000_0020, 32'h1111_1111, 1, 1'b1);
    xfer(1'b0, 32'h0000_0020, 32'h0, 0);

    xfer(1'b0, 32'h0000_0010, 32'h0, 0, 1'b1);
    xfer(1'b0, 32'h0000_0010, 32'h0, 0);
    xfer(1'b1, 32'h0000_0024, 32'hCAFE_F00D, 0, 1'b1);
    xfer(1'b0, 32'h0000_0024, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      w   = 1'($urandom_range(0, 1));
      key = int'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0)
        a = $urandom | 32'h0000_1000;
      else
        a = BASE + 32'(key * 4) + 32'($urandom_range(0, 3));
      if (!w && in_win(a) && !model_mem.exists(word_key(a))) w = 1'b1;
      if ($urandom_range(0, 9) == 0)
        abort_xfer(w, a, $urandom, int'($urandom_range(1, 2)), 1'b0);
      else
        xfer(w, a, $urandom, int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
